// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath select codes and the decoded control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALTED = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    pc_src_t    pc_source;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  // States that talk to memory and therefore dwell MEM_WAIT+1 cycles.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode/zero/halt in, enables and selects out.
interface multicycle_control_if;
  logic       halt;
  logic [5:0] opcode;
  logic       zero;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       pc_en;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic       illegal;

  // master: the control unit
  modport master (
    input  halt, opcode, zero,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, pc_en, PCSource, ALUSrcB, ALUop, state, illegal
  );

  // slave: the datapath
  modport slave (
    output halt, opcode, zero,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, pc_en, PCSource, ALUSrcB, ALUop, state, illegal
  );
endinterface

// File: rtl/multicycle_control_op_decode.sv
// Opcode decoder: where DECODE goes next, the ALU op for immediate
// instructions, and whether a memory instruction is a load.
module op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     next_state,
  output alu_op_t    imm_alu_op,
  output logic       is_load
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = S_TRAP;
    imm_alu_op = ALU_ADD;
    is_load    = 1'b0;
    case (opcode)
      OP_RTYPE: next_state = S_EXEC;
      OP_LW: begin
        next_state = S_MEMADR;
        is_load    = 1'b1;
      end
      OP_SW:    next_state = S_MEMADR;
      OP_BEQ:   next_state = S_BRANCH;
      OP_J:     next_state = S_JUMP;
      OP_ADDI:  next_state = S_IEXEC;
      OP_ANDI: begin
        next_state = S_IEXEC;
        imm_alu_op = ALU_AND;
      end
      OP_ORI: begin
        next_state = S_IEXEC;
        imm_alu_op = ALU_OR;
      end
      OP_SLTI: begin
        next_state = S_IEXEC;
        imm_alu_op = ALU_SLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with configurable memory wait states,
// halt handling and a sticky illegal-opcode trap.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       illegal_q;
  logic       run_q;
  ctrl_t      ctrl;

  state_t  dec_next;
  alu_op_t imm_alu_op;
  logic    is_load;

  op_decode u_op_decode (
    .opcode     (bus.opcode),
    .next_state (dec_next),
    .imm_alu_op (imm_alu_op),
    .is_load    (is_load)
  );

  logic last_wait;
  logic halt_take;
  assign last_wait = (wait_q == 4'd0);
  // Halt is honoured on the FETCH entry cycle; the fetch writes are then
  // suppressed so the next instruction is not consumed before halting.
  assign halt_take = (state_q == S_FETCH) && (wait_q == WAIT_INIT) && bus.halt;

  // run_q keeps the FSM parked with enables low for the first cycle after reset release.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= WAIT_INIT;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        state_q   <= state_d;
        wait_q    <= wait_d;
        illegal_q <= illegal_q | (state_d == S_TRAP);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (halt_take)      state_d = S_HALTED;
        else if (last_wait) state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_next;
      S_MEMADR: state_d = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (last_wait) state_d = S_MEMWB;
      S_MEMWR:  if (last_wait) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
      S_HALTED: if (!bus.halt) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // The counter is reloaded on every state change, so it is full on entry.
    if (state_d != state_q)
      wait_d = WAIT_INIT;
    else if (is_mem_state(state_q) && !last_wait)
      wait_d = wait_q - 4'd1;
    else
      wait_d = wait_q;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = last_wait && !halt_take;
        ctrl.pc_write  = last_wait && !halt_take;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = last_wait;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated by run_q, which clears asynchronously with reset.
  assign bus.PCWrite     = run_q & ctrl.pc_write;
  assign bus.PCWriteCond = run_q & ctrl.pc_write_cond;
  assign bus.MemRead     = run_q & ctrl.mem_read;
  assign bus.MemWrite    = run_q & ctrl.mem_write;
  assign bus.IRWrite     = run_q & ctrl.ir_write;
  assign bus.RegWrite    = run_q & ctrl.reg_write;
  assign bus.pc_en       = run_q & (ctrl.pc_write | (ctrl.pc_write_cond & bus.zero));
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUop       = ctrl.alu_op;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table on a
// MEM_WAIT=0 instance, plus hand sequences for reset and wait-state corners.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       srca;
    logic       rw;
    logic       rdst;
    logic [1:0] pcsrc;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       ill;
  } obs_t;

  typedef struct {
    logic       halt;
    logic [5:0] op;
    logic       zero;
    obs_t       exp;
  } vec_t;

  localparam obs_t O_FETCH      = '{st:4'd0, pc_en:1'b1, pcw:1'b1, mrd:1'b1, irw:1'b1, srcb:2'b01, default:'0};
  localparam obs_t O_FETCH_IDLE = '{st:4'd0, srcb:2'b01, default:'0};
  localparam obs_t O_FETCH_WAIT = '{st:4'd0, mrd:1'b1, srcb:2'b01, default:'0};
  localparam obs_t O_DECODE     = '{st:4'd1, srcb:2'b11, default:'0};
  localparam obs_t O_MEMADR     = '{st:4'd2, srca:1'b1, srcb:2'b10, default:'0};
  localparam obs_t O_MEMRD      = '{st:4'd3, iord:1'b1, mrd:1'b1, default:'0};
  localparam obs_t O_MEMWB      = '{st:4'd4, rw:1'b1, m2r:1'b1, default:'0};
  localparam obs_t O_MEMWR      = '{st:4'd5, iord:1'b1, mwr:1'b1, default:'0};
  localparam obs_t O_MEMWR_WAIT = '{st:4'd5, iord:1'b1, default:'0};
  localparam obs_t O_EXEC       = '{st:4'd6, srca:1'b1, aluop:3'b010, default:'0};
  localparam obs_t O_ALUWB      = '{st:4'd7, rw:1'b1, rdst:1'b1, default:'0};
  localparam obs_t O_BEQ_T      = '{st:4'd8, pc_en:1'b1, pcwc:1'b1, srca:1'b1, pcsrc:2'b01, aluop:3'b001, default:'0};
  localparam obs_t O_BEQ_N      = '{st:4'd8, pcwc:1'b1, srca:1'b1, pcsrc:2'b01, aluop:3'b001, default:'0};
  localparam obs_t O_JUMP       = '{st:4'd9, pc_en:1'b1, pcw:1'b1, pcsrc:2'b10, default:'0};
  localparam obs_t O_IADD       = '{st:4'd10, srca:1'b1, srcb:2'b10, aluop:3'b000, default:'0};
  localparam obs_t O_IAND       = '{st:4'd10, srca:1'b1, srcb:2'b10, aluop:3'b011, default:'0};
  localparam obs_t O_IOR        = '{st:4'd10, srca:1'b1, srcb:2'b10, aluop:3'b100, default:'0};
  localparam obs_t O_ISLT       = '{st:4'd10, srca:1'b1, srcb:2'b10, aluop:3'b101, default:'0};
  localparam obs_t O_IWB        = '{st:4'd11, rw:1'b1, default:'0};
  localparam obs_t O_HALTED     = '{st:4'd12, default:'0};
  localparam obs_t O_TRAP       = '{st:4'd13, ill:1'b1, default:'0};

  logic clk = 1'b0;
  logic rst0, rst2;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control_if bus0 ();
  multicycle_control_if bus2 ();

  multicycle_control #(.MEM_WAIT(0)) dut0 (.clock(clk), .reset(rst0), .bus(bus0));
  multicycle_control #(.MEM_WAIT(2)) dut2 (.clock(clk), .reset(rst2), .bus(bus2));

  function automatic obs_t obs0();
    return '{st:bus0.state, pc_en:bus0.pc_en, pcw:bus0.PCWrite, pcwc:bus0.PCWriteCond,
             iord:bus0.IorD, mrd:bus0.MemRead, mwr:bus0.MemWrite, irw:bus0.IRWrite,
             m2r:bus0.MemtoReg, srca:bus0.ALUSrcA, rw:bus0.RegWrite, rdst:bus0.RegDst,
             pcsrc:bus0.PCSource, srcb:bus0.ALUSrcB, aluop:bus0.ALUop, ill:bus0.illegal};
  endfunction

  function automatic obs_t obs2();
    return '{st:bus2.state, pc_en:bus2.pc_en, pcw:bus2.PCWrite, pcwc:bus2.PCWriteCond,
             iord:bus2.IorD, mrd:bus2.MemRead, mwr:bus2.MemWrite, irw:bus2.IRWrite,
             m2r:bus2.MemtoReg, srca:bus2.ALUSrcA, rw:bus2.RegWrite, rdst:bus2.RegDst,
             pcsrc:bus2.PCSource, srcb:bus2.ALUSrcB, aluop:bus2.ALUop, ill:bus2.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic [5:0] op, input logic z, input obs_t e);
    vec_t v;
    v.halt = h;
    v.op   = op;
    v.zero = z;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t seq2[9];

    // lw, sw, R-type
    add(0, 6'b100011, 0, O_FETCH); add(0, 6'b100011, 0, O_DECODE); add(0, 6'b100011, 0, O_MEMADR);
    add(0, 6'b100011, 0, O_MEMRD); add(0, 6'b100011, 0, O_MEMWB);
    add(0, 6'b101011, 0, O_FETCH); add(0, 6'b101011, 0, O_DECODE); add(0, 6'b101011, 0, O_MEMADR);
    add(0, 6'b101011, 0, O_MEMWR);
    add(0, 6'b000000, 0, O_FETCH); add(0, 6'b000000, 0, O_DECODE); add(0, 6'b000000, 0, O_EXEC);
    add(0, 6'b000000, 0, O_ALUWB);
    // beq taken / not taken, j
    add(0, 6'b000100, 1, O_FETCH); add(0, 6'b000100, 1, O_DECODE); add(0, 6'b000100, 1, O_BEQ_T);
    add(0, 6'b000100, 0, O_FETCH); add(0, 6'b000100, 0, O_DECODE); add(0, 6'b000100, 0, O_BEQ_N);
    add(0, 6'b000010, 0, O_FETCH); add(0, 6'b000010, 0, O_DECODE); add(0, 6'b000010, 0, O_JUMP);
    // immediates
    add(0, 6'b001000, 0, O_FETCH); add(0, 6'b001000, 0, O_DECODE); add(0, 6'b001000, 0, O_IADD);
    add(0, 6'b001000, 0, O_IWB);
    add(0, 6'b001100, 0, O_FETCH); add(0, 6'b001100, 0, O_DECODE); add(0, 6'b001100, 0, O_IAND);
    add(0, 6'b001100, 0, O_IWB);
    add(0, 6'b001101, 0, O_FETCH); add(0, 6'b001101, 0, O_DECODE); add(0, 6'b001101, 0, O_IOR);
    add(0, 6'b001101, 0, O_IWB);
    add(0, 6'b001010, 0, O_FETCH); add(0, 6'b001010, 0, O_DECODE); add(0, 6'b001010, 0, O_ISLT);
    add(0, 6'b001010, 0, O_IWB);
    // halt raised during EXEC: ALUWB completes, FETCH entry halts without writes
    add(0, 6'b000000, 0, O_FETCH); add(0, 6'b000000, 0, O_DECODE); add(1, 6'b000000, 0, O_EXEC);
    add(1, 6'b000000, 0, O_ALUWB); add(1, 6'b000000, 0, O_FETCH_WAIT); add(1, 6'b000000, 0, O_HALTED);
    add(0, 6'b000000, 0, O_HALTED);
    add(0, 6'b000010, 0, O_FETCH); add(0, 6'b000010, 0, O_DECODE); add(0, 6'b000010, 0, O_JUMP);
    // illegal opcode traps and stays trapped
    add(0, 6'b111111, 0, O_FETCH); add(0, 6'b111111, 0, O_DECODE); add(0, 6'b111111, 0, O_TRAP);
    add(0, 6'b000000, 0, O_TRAP);

    rst0 = 1'b0;
    rst2 = 1'b0;
    bus0.halt = 1'b0; bus0.opcode = 6'b100011; bus0.zero = 1'b0;
    bus2.halt = 1'b0; bus2.opcode = 6'b101011; bus2.zero = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state_w0", obs0(), O_FETCH_IDLE);
    check("reset_state_w2", obs2(), O_FETCH_IDLE);
    @(posedge clk);
    #1 rst0 = 1'b1;
    @(negedge clk);
    check("post_release_idle", obs0(), O_FETCH_IDLE);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      bus0.halt   = vecs[i].halt;
      bus0.opcode = vecs[i].op;
      bus0.zero   = vecs[i].zero;
      @(negedge clk);
      check($sformatf("vec%0d_state%0d", i, vecs[i].exp.st), obs0(), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset out of TRAP clears illegal and state without an edge.
    @(negedge clk);
    #2 rst0 = 1'b0;
    #1 check("trap_async_reset", obs0(), O_FETCH_IDLE);
    @(posedge clk);
    #1 rst0 = 1'b1;
    bus0.opcode = 6'b100011;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("memwb_before_pulse", obs0(), O_MEMWB);
    #2 rst0 = 1'b0;
    #1 check("memwb_regwrite_async", {31'd0, bus0.RegWrite}, 32'd0);
    check("memwb_async_state", obs0(), O_FETCH_IDLE);
    @(posedge clk);
    #1 rst0 = 1'b1;

    // MEM_WAIT=2 store: three-cycle FETCH and MEMWR, strobes on the last cycle only.
    seq2 = '{O_FETCH_WAIT, O_FETCH_WAIT, O_FETCH, O_DECODE, O_MEMADR,
             O_MEMWR_WAIT, O_MEMWR_WAIT, O_MEMWR, O_FETCH_WAIT};
    @(posedge clk);
    #1 rst2 = 1'b1;
    @(posedge clk);
    #1;
    foreach (seq2[i]) begin
      @(negedge clk);
      check($sformatf("wait2_cycle%0d", i), obs2(), seq2[i]);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
